// File: rtl/prod_accum.sv
// prod_accum: accumulates COUNT signed products from the multiplier into a
// wider two's-complement sum and offers each finished sum on a valid/ready
// port, stalling the multiplier side while a sum waits to be taken.
module prod_accum #(
  parameter int WIDTH = 8,
  parameter int COUNT = 4,
  parameter int ACC_W = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2*WIDTH-1:0] p,
  input  logic               rdy,
  output logic               in_ready,
  input  logic               clear,
  output logic [ACC_W-1:0]   sum,
  output logic               sum_valid,
  input  logic               sum_ready
);

  localparam int P_W   = 2 * WIDTH;
  localparam int EXT_W = ACC_W - P_W;
  localparam int CNT_W = (COUNT > 2) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(COUNT - 1);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_next;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic [ACC_W-1:0]   sum_q;
  logic [ACC_W-1:0]   sum_next;
  logic [ACC_W-1:0]   p_ext;
  logic [ACC_W-1:0]   acc_plus;
  logic               accept;
  logic               last_product;

  // Sign-extend the product, form the running total, and decode the accept strobe.
  always_comb begin
    p_ext        = {{EXT_W{p[P_W-1]}}, p};
    acc_plus     = acc + p_ext;
    accept       = rdy && (state == ACC);
    last_product = (count == LAST_IDX);
  end

  // Next-state and datapath update; clear overrides both accept and handshake.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    count_next = count;
    sum_next   = sum_q;
    if (clear) begin
      state_next = ACC;
      acc_next   = '0;
      count_next = '0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            if (last_product) begin
              sum_next   = acc_plus;
              acc_next   = '0;
              count_next = '0;
              state_next = HOLD;
            end else begin
              acc_next   = acc_plus;
              count_next = count + 1'b1;
            end
          end
        end
        HOLD: begin
          if (sum_ready) begin
            state_next = ACC;
          end
        end
        default: begin
          state_next = ACC;
        end
      endcase
    end
  end

  // State, accumulator, product counter and held sum registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ACC;
      acc   <= '0;
      count <= '0;
      sum_q <= '0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      count <= count_next;
      sum_q <= sum_next;
    end
  end

  // Handshake flags come straight off the state register.
  always_comb begin
    in_ready  = (state == ACC);
    sum_valid = (state == HOLD);
    sum       = sum_q;
  end

endmodule

// File: tb/tb_prod_accum.sv
// tb_prod_accum: directed checks of the product accumulator with hand-computed sums.
module tb_prod_accum;

  localparam int WIDTH = 8;
  localparam int COUNT = 4;
  localparam int ACC_W = 20;

  logic               clk;
  logic               reset;
  logic [2*WIDTH-1:0] p;
  logic               rdy;
  logic               in_ready;
  logic               clear;
  logic [ACC_W-1:0]   sum;
  logic               sum_valid;
  logic               sum_ready;

  int n_checks;
  int n_fail;

  prod_accum #(
    .WIDTH(WIDTH),
    .COUNT(COUNT),
    .ACC_W(ACC_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .p(p),
    .rdy(rdy),
    .in_ready(in_ready),
    .clear(clear),
    .sum(sum),
    .sum_valid(sum_valid),
    .sum_ready(sum_ready)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then advance past the next rising edge.
  task automatic applyStimulus(input logic r, input logic [2*WIDTH-1:0] pv,
                               input logic sr, input logic cl);
    rdy       = r;
    p         = pv;
    sum_ready = sr;
    clear     = cl;
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value to its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Check both handshake flags at once.
  task automatic checkFlags(input string tag, input logic exp_in_ready, input logic exp_valid);
    checkOutput({tag, ".in_ready"}, {31'b0, in_ready}, {31'b0, exp_in_ready});
    checkOutput({tag, ".sum_valid"}, {31'b0, sum_valid}, {31'b0, exp_valid});
  endtask

  // Directed test sequence.
  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    rdy       = 1'b0;
    p         = '0;
    clear     = 1'b0;
    sum_ready = 1'b0;
    @(posedge clk);
    #1;
    checkFlags("reset", 1'b1, 1'b0);
    checkOutput("reset.sum", {12'b0, sum}, 32'h0);
    reset = 1'b0;

    // Mixed-sign products, consumer always ready.
    applyStimulus(1'b1, 16'd15, 1'b1, 1'b0);
    applyStimulus(1'b1, -16'sd14, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'd16129, 1'b1, 1'b0);
    checkFlags("t1.before_last", 1'b1, 1'b0);
    applyStimulus(1'b1, 16'd16384, 1'b1, 1'b0);
    checkFlags("t1.hold", 1'b0, 1'b1);
    checkOutput("t1.sum", {12'b0, sum}, 32'h07F02);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
    checkFlags("t1.after", 1'b1, 1'b0);

    // Negative sum must sign-extend correctly in 20 bits.
    repeat (4) applyStimulus(1'b1, -16'sd16256, 1'b1, 1'b0);
    checkFlags("t2.hold", 1'b0, 1'b1);
    checkOutput("t2.sum", {12'b0, sum}, 32'hF0200);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
    checkFlags("t2.after", 1'b1, 1'b0);

    // Backpressure: products offered during HOLD must be ignored.
    repeat (4) applyStimulus(1'b1, 16'd7, 1'b0, 1'b0);
    checkOutput("t3.first_sum", {12'b0, sum}, 32'd28);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 16'd100, 1'b0, 1'b0);
      checkFlags("t3.stall", 1'b0, 1'b1);
      checkOutput("t3.stall_sum", {12'b0, sum}, 32'd28);
    end
    applyStimulus(1'b1, 16'd100, 1'b1, 1'b0);
    checkFlags("t3.release", 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b1, 16'd100, 1'b1, 1'b0);
    checkFlags("t3.three_in", 1'b1, 1'b0);
    applyStimulus(1'b1, 16'd100, 1'b1, 1'b0);
    checkFlags("t3.hold2", 1'b0, 1'b1);
    checkOutput("t3.sum400", {12'b0, sum}, 32'd400);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);

    // Clear discards a partial sum.
    applyStimulus(1'b1, 16'd1000, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'd2000, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b1);
    checkFlags("t4.cleared", 1'b1, 1'b0);
    repeat (4) applyStimulus(1'b1, 16'd1, 1'b1, 1'b0);
    checkFlags("t4.hold", 1'b0, 1'b1);
    checkOutput("t4.sum", {12'b0, sum}, 32'd4);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);

    // Gaps in rdy: count advances only on accepted products.
    applyStimulus(1'b1, 16'd3, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'd3, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'd3, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'd3, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'd3, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'd3, 1'b1, 1'b0);
    checkFlags("t5.three_in", 1'b1, 1'b0);
    applyStimulus(1'b1, 16'd3, 1'b1, 1'b0);
    checkFlags("t5.hold", 1'b0, 1'b1);
    checkOutput("t5.sum", {12'b0, sum}, 32'd12);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);

    // Asynchronous reset mid-accumulation.
    applyStimulus(1'b1, 16'd9, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'd9, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkFlags("t6.reset_acc", 1'b1, 1'b0);
    checkOutput("t6.reset_acc.sum", {12'b0, sum}, 32'h0);
    @(posedge clk);
    #1;
    checkFlags("t6.reset_held", 1'b1, 1'b0);
    reset = 1'b0;

    // Asynchronous reset while a sum is held.
    repeat (4) applyStimulus(1'b1, 16'd9, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b0);
    checkFlags("t6.hold36", 1'b0, 1'b1);
    checkOutput("t6.sum36", {12'b0, sum}, 32'd36);
    #2;
    reset = 1'b1;
    #1;
    checkFlags("t6.reset_hold", 1'b1, 1'b0);
    checkOutput("t6.reset_hold.sum", {12'b0, sum}, 32'h0);
    #2;
    reset = 1'b0;
    repeat (4) applyStimulus(1'b1, 16'd5, 1'b1, 1'b0);
    checkFlags("t6.hold20", 1'b0, 1'b1);
    checkOutput("t6.sum20", {12'b0, sum}, 32'd20);

    // Clear and handshake in the same HOLD cycle resolve to ACC.
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b1);
    checkFlags("t7.clear_hold", 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
